// File: rtl/pipe_pkg.sv
// Shared pipeline control definitions.
//   FWD_DX/FWD_XM/FWD_MW : X-stage operand source select encodings
//   REG_ZERO             : hardwired-zero register address
//   stage_t              : shadow copy of one stage's register fields
// Register fields are stored at MAX_REG_W bits so the struct can live here while the
// controller keeps REG_W as a parameter; narrower addresses are zero-extended on entry.
package pipe_pkg;

    localparam logic [1:0] FWD_DX = 2'd0;
    localparam logic [1:0] FWD_XM = 2'd1;
    localparam logic [1:0] FWD_MW = 2'd2;

    localparam int unsigned MAX_REG_W = 8;

    localparam logic [MAX_REG_W-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [MAX_REG_W-1:0] rd;
        logic                 wen;
        logic                 is_load;
        logic [MAX_REG_W-1:0] rs_a;
        logic                 use_a;
        logic [MAX_REG_W-1:0] rs_b;
        logic                 use_b;
    } stage_t;

    localparam stage_t STAGE_BUBBLE = '0;

    // A source depends on rd only if it is really read and is not r0.
    function automatic logic src_hit(input logic                 use_src,
                                     input logic [MAX_REG_W-1:0] src,
                                     input logic [MAX_REG_W-1:0] rd);
        return use_src && (src != REG_ZERO) && (src == rd);
    endfunction

endpackage

// File: rtl/md_tracker.sv
// Tracks the single in-flight multi-cycle mult/div operation.
//   clock, reset  : clock, synchronous active-high reset
//   start_req     : md instruction issues from D this cycle
//   start_rd      : its destination register
//   w_wen         : shadow W stage writes the regfile this cycle
//   md_start      : one-cycle start pulse (instruction is in X)
//   md_capture    : result valid, datapath latches it
//   md_hold       : latched result waiting for a free writeback slot
//   md_wb_valid   : regfile write port takes the held result
//   md_busy       : op in flight or result held
//   md_rd         : destination of the tracked op
module md_tracker import pipe_pkg::*; #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_req,
    input  logic [REG_W-1:0] start_rd,
    input  logic             w_wen,
    output logic             md_start,
    output logic             md_capture,
    output logic             md_hold,
    output logic             md_wb_valid,
    output logic             md_busy,
    output logic [REG_W-1:0] md_rd
);

    localparam int unsigned CNT_W = $clog2(MD_LATENCY + 1);

    logic [CNT_W-1:0] cnt_q;
    logic             start_q;
    logic             hold_q;
    logic [REG_W-1:0] rd_q;

    // Counter loads on the start cycle and counts down; capture fires when it reads 1,
    // which lands exactly MD_LATENCY cycles after md_start.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            start_q <= 1'b0;
            hold_q  <= 1'b0;
            rd_q    <= '0;
        end else begin
            start_q <= start_req;
            if (start_req) begin
                rd_q <= start_rd;
            end
            if (start_q) begin
                cnt_q <= CNT_W'(MD_LATENCY);
            end else if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (md_capture) begin
                hold_q <= 1'b1;
            end else if (md_wb_valid) begin
                hold_q <= 1'b0;
            end
        end
    end

    assign md_start    = start_q;
    assign md_capture  = (cnt_q == CNT_W'(1));
    assign md_hold     = hold_q;
    // The normal W path owns the write port; the held result takes the first idle slot.
    assign md_wb_valid = hold_q & ~w_wen;
    assign md_busy     = start_q | (cnt_q != '0) | hold_q;
    assign md_rd       = rd_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard, interlock and bypass controller for the 5-stage pipeline.
//   clock, reset            : clock, synchronous active-high reset
//   d_*                     : decoded fields of the instruction in D
//   flush                   : taken branch/jump resolved in X
//   stall / issue           : hold PC+FD with a DX bubble / D enters X at next edge
//   fwd_sel_a, fwd_sel_b    : X-stage operand source (DX, XM result, MW writeback)
//   md_start .. md_wb_rd    : multdiv start/capture/writeback steering
module hazard_scoreboard import pipe_pkg::*; #(
    parameter int unsigned REG_W      = 5,
    parameter int unsigned MD_LATENCY = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             d_valid,
    input  logic [REG_W-1:0] d_rs_a,
    input  logic [REG_W-1:0] d_rs_b,
    input  logic             d_use_a,
    input  logic             d_use_b,
    input  logic [REG_W-1:0] d_rd,
    input  logic             d_wen,
    input  logic             d_is_load,
    input  logic             d_is_md,
    input  logic             flush,
    output logic             stall,
    output logic             issue,
    output logic [1:0]       fwd_sel_a,
    output logic [1:0]       fwd_sel_b,
    output logic             md_start,
    output logic             md_busy,
    output logic [REG_W-1:0] md_rd,
    output logic             md_capture,
    output logic             md_wb_valid,
    output logic [REG_W-1:0] md_wb_rd
);

    typedef logic [MAX_REG_W-1:0] reg_t;

    stage_t d_stage;
    stage_t x_q, m_q, w_q;
    logic   md_hold;
    logic   load_use, md_raw, md_waw, md_struct, hazard;
    reg_t   md_rd_ext;

    // md results go through the hold path, so the shadow copy never claims the W write.
    always_comb begin
        d_stage         = STAGE_BUBBLE;
        d_stage.rd      = reg_t'(d_rd);
        d_stage.wen     = d_wen & ~d_is_md;
        d_stage.is_load = d_is_load;
        d_stage.rs_a    = reg_t'(d_rs_a);
        d_stage.use_a   = d_use_a;
        d_stage.rs_b    = reg_t'(d_rs_b);
        d_stage.use_b   = d_use_b;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            x_q <= STAGE_BUBBLE;
            m_q <= STAGE_BUBBLE;
            w_q <= STAGE_BUBBLE;
        end else begin
            x_q <= issue ? d_stage : STAGE_BUBBLE;
            m_q <= x_q;
            w_q <= m_q;
        end
    end

    md_tracker #(
        .REG_W      (REG_W),
        .MD_LATENCY (MD_LATENCY)
    ) u_md_tracker (
        .clock       (clock),
        .reset       (reset),
        .start_req   (issue & d_is_md),
        .start_rd    (d_rd),
        .w_wen       (w_q.wen),
        .md_start    (md_start),
        .md_capture  (md_capture),
        .md_hold     (md_hold),
        .md_wb_valid (md_wb_valid),
        .md_busy     (md_busy),
        .md_rd       (md_rd)
    );

    assign md_wb_rd  = md_rd;
    assign md_rd_ext = reg_t'(md_rd);

    always_comb begin
        load_use  = x_q.is_load & x_q.wen & (x_q.rd != REG_ZERO) &
                    (src_hit(d_use_a, d_stage.rs_a, x_q.rd) |
                     src_hit(d_use_b, d_stage.rs_b, x_q.rd));
        md_raw    = md_busy & (md_rd_ext != REG_ZERO) &
                    (src_hit(d_use_a, d_stage.rs_a, md_rd_ext) |
                     src_hit(d_use_b, d_stage.rs_b, md_rd_ext));
        md_waw    = md_busy & d_wen & (md_rd_ext != REG_ZERO) & (d_stage.rd == md_rd_ext);
        md_struct = d_is_md & md_busy;
        hazard    = load_use | md_raw | md_waw | md_struct | md_hold;
    end

    // Flush wins over any hazard so the PC can take the branch target.
    assign stall = d_valid & hazard & ~flush;
    assign issue = d_valid & ~stall & ~flush;

    function automatic logic [1:0] bypass(input reg_t src, input stage_t m, input stage_t w);
        if (m.wen && (m.rd != REG_ZERO) && (m.rd == src)) begin
            return FWD_XM;
        end else if (w.wen && (w.rd != REG_ZERO) && (w.rd == src)) begin
            return FWD_MW;
        end
        return FWD_DX;
    endfunction

    assign fwd_sel_a = bypass(x_q.rs_a, m_q, w_q);
    assign fwd_sel_b = bypass(x_q.rs_b, m_q, w_q);

    // Shadow fields kept for visibility but not needed by the control equations.
    logic unused_shadow;
    assign unused_shadow = ^{x_q.use_a, x_q.use_b,
                             m_q.is_load, m_q.rs_a, m_q.use_a, m_q.rs_b, m_q.use_b,
                             w_q.is_load, w_q.rs_a, w_q.use_a, w_q.rs_b, w_q.use_b};

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with MD_LATENCY=4. A driver applies one D-stage
// vector per cycle and queues the hand-computed outputs for that cycle; a monitor pops
// and compares on the falling edge.
module tb_hazard_scoreboard;

    localparam int unsigned REG_W      = 5;
    localparam int unsigned MD_LATENCY = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             d_valid = 1'b0;
    logic [REG_W-1:0] d_rs_a = '0;
    logic [REG_W-1:0] d_rs_b = '0;
    logic             d_use_a = 1'b0;
    logic             d_use_b = 1'b0;
    logic [REG_W-1:0] d_rd = '0;
    logic             d_wen = 1'b0;
    logic             d_is_load = 1'b0;
    logic             d_is_md = 1'b0;
    logic             flush = 1'b0;
    logic             stall, issue, md_start, md_busy, md_capture, md_wb_valid;
    logic [1:0]       fwd_sel_a, fwd_sel_b;
    logic [REG_W-1:0] md_rd, md_wb_rd;

    hazard_scoreboard #(
        .REG_W      (REG_W),
        .MD_LATENCY (MD_LATENCY)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .d_valid     (d_valid),
        .d_rs_a      (d_rs_a),
        .d_rs_b      (d_rs_b),
        .d_use_a     (d_use_a),
        .d_use_b     (d_use_b),
        .d_rd        (d_rd),
        .d_wen       (d_wen),
        .d_is_load   (d_is_load),
        .d_is_md     (d_is_md),
        .flush       (flush),
        .stall       (stall),
        .issue       (issue),
        .fwd_sel_a   (fwd_sel_a),
        .fwd_sel_b   (fwd_sel_b),
        .md_start    (md_start),
        .md_busy     (md_busy),
        .md_rd       (md_rd),
        .md_capture  (md_capture),
        .md_wb_valid (md_wb_valid),
        .md_wb_rd    (md_wb_rd)
    );

    always #5 clock = ~clock;

    typedef struct {
        int cyc;
        int stall;
        int issue;
        int fa;
        int fb;
        int start;
        int busy;
        int cap;
        int wbv;
        int mdrd;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   cyc    = -1;

    task automatic drive(input logic rst, input logic v, input int rd, input int ra,
                         input int rb, input logic ua, input logic ub, input logic wen,
                         input logic ld, input logic md, input logic fl);
        @(posedge clock);
        #1;
        reset     = rst;
        d_valid   = v;
        d_rd      = 5'(rd);
        d_rs_a    = 5'(ra);
        d_rs_b    = 5'(rb);
        d_use_a   = ua;
        d_use_b   = ub;
        d_wen     = wen;
        d_is_load = ld;
        d_is_md   = md;
        flush     = fl;
        cyc++;
    endtask

    task automatic nop();               drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic rst_cyc();           drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic alu(input int rd, input int ra, input int rb);
        drive(0, 1, rd, ra, rb, 1, 1, 1, 0, 0, 0);
    endtask
    task automatic lw(input int rd, input int ra);
        drive(0, 1, rd, ra, 0, 1, 0, 1, 1, 0, 0);
    endtask
    task automatic mul(input int rd, input int ra, input int rb);
        drive(0, 1, rd, ra, rb, 1, 1, 1, 0, 1, 0);
    endtask

    // Expected outputs for the cycle just driven.
    task automatic ex(input int s, input int i, input int fa, input int fb, input int st,
                      input int bz, input int cp, input int wb, input int rd);
        exp_t e;
        e.cyc = cyc; e.stall = s; e.issue = i; e.fa = fa; e.fb = fb;
        e.start = st; e.busy = bz; e.cap = cp; e.wbv = wb; e.mdrd = rd;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input int c, input int act, input int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0d, expected %0d", name, c, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("stall",       e.cyc, int'(stall),       e.stall);
                chk("issue",       e.cyc, int'(issue),       e.issue);
                chk("fwd_sel_a",   e.cyc, int'(fwd_sel_a),   e.fa);
                chk("fwd_sel_b",   e.cyc, int'(fwd_sel_b),   e.fb);
                chk("md_start",    e.cyc, int'(md_start),    e.start);
                chk("md_busy",     e.cyc, int'(md_busy),     e.busy);
                chk("md_capture",  e.cyc, int'(md_capture),  e.cap);
                chk("md_wb_valid", e.cyc, int'(md_wb_valid), e.wbv);
                chk("md_rd",       e.cyc, int'(md_rd),       e.mdrd);
                chk("md_wb_rd",    e.cyc, int'(md_wb_rd),    e.mdrd);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        // Reset state, then release.
        rst_cyc();      ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Back-to-back ALU dependency: XM bypass, then MW, then none.
        alu(3, 1, 2);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        alu(4, 3, 3);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 1, 1, 0, 0, 0, 0, 0);
        alu(3, 1, 2);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        alu(4, 3, 3);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 2, 2, 0, 0, 0, 0, 0);
        alu(3, 1, 2);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        alu(4, 3, 3);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use: one stall, then MW bypass.
        lw(5, 1);       ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        alu(6, 5, 2);   ex(1, 0, 0, 0, 0, 0, 0, 0, 0);
        alu(6, 5, 2);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 2, 0, 0, 0, 0, 0, 0);

        // Load-use hazard coinciding with flush.
        lw(5, 1);       ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 6, 5, 2, 1, 1, 1, 0, 0, 1);
                        ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // r0 destinations never stall or bypass.
        alu(0, 1, 2);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        alu(7, 0, 0);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        lw(0, 1);       ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        alu(8, 0, 0);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // mul r7, dependent add stalls until the held result is written.
        mul(7, 1, 2);   ex(0, 1, 0, 0, 0, 0, 0, 0, 0);
        alu(9, 7, 1);   ex(1, 0, 0, 0, 1, 1, 0, 0, 7);
        alu(9, 7, 1);   ex(1, 0, 0, 0, 0, 1, 0, 0, 7);
        alu(9, 7, 1);   ex(1, 0, 0, 0, 0, 1, 0, 0, 7);
        alu(9, 7, 1);   ex(1, 0, 0, 0, 0, 1, 0, 0, 7);
        alu(9, 7, 1);   ex(1, 0, 0, 0, 0, 1, 1, 0, 7);
        alu(9, 7, 1);   ex(1, 0, 0, 0, 0, 1, 0, 1, 7);
        alu(9, 7, 1);   ex(0, 1, 0, 0, 0, 0, 0, 0, 7);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 7);

        // mul r10 captured while three ALU writes occupy W: writeback deferred 3 cycles.
        mul(10, 1, 2);  ex(0, 1, 0, 0, 0, 0, 0, 0, 7);
        nop();          ex(0, 0, 0, 0, 1, 1, 0, 0, 10);
        nop();          ex(0, 0, 0, 0, 0, 1, 0, 0, 10);
        alu(11, 1, 2);  ex(0, 1, 0, 0, 0, 1, 0, 0, 10);
        alu(12, 1, 2);  ex(0, 1, 0, 0, 0, 1, 0, 0, 10);
        alu(13, 1, 2);  ex(0, 1, 0, 0, 0, 1, 1, 0, 10);
        alu(14, 11, 12); ex(1, 0, 0, 0, 0, 1, 0, 0, 10);
        alu(14, 11, 12); ex(1, 0, 0, 0, 0, 1, 0, 0, 10);
        alu(14, 11, 12); ex(1, 0, 0, 0, 0, 1, 0, 0, 10);
        alu(14, 11, 12); ex(1, 0, 0, 0, 0, 1, 0, 1, 10);
        alu(14, 11, 12); ex(0, 1, 0, 0, 0, 0, 0, 0, 10);
        nop();          ex(0, 0, 0, 0, 0, 0, 0, 0, 10);

        // WAW and structural stalls, then reset two cycles after md_start.
        mul(15, 1, 2);  ex(0, 1, 0, 0, 0, 0, 0, 0, 10);
        alu(15, 1, 2);  ex(1, 0, 0, 0, 1, 1, 0, 0, 15);
        mul(16, 1, 2);  ex(1, 0, 0, 0, 0, 1, 0, 0, 15);
        rst_cyc();      ex(0, 0, 0, 0, 0, 1, 0, 0, 15);
        for (int k = 0; k < 6; k++) begin
            nop();      ex(0, 0, 0, 0, 0, 0, 0, 0, 0);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) begin
            @(negedge clock);
        end
        #1;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
